// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if
//   Valid/ready stream carrying words fetched from the dual-port RAM.
//   Ports (signals):
//     m_data  - stream data word, driven by the reader
//     m_valid - stream valid, driven by the reader
//     m_ready - stream ready, driven by the consumer
//   Modports: master (reader side), slave (consumer side).
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side engine for a RAM with a registered read address (data one
//   cycle after raddr is sampled). A start command fetches `length`
//   consecutive words from `start_addr` (wrapping modulo the RAM depth) and
//   presents them in order on a valid/ready stream with full back-pressure.
//   Ports:
//     clk, sync_reset    - clock and synchronous active-high reset
//     start              - command pulse, honoured only while not busy
//     start_addr, length - block descriptor captured with start
//     busy, done         - transfer in progress / one-cycle completion pulse
//     ram_raddr          - RAM read address
//     ram_dout           - RAM read data
//     m                  - output stream (master modport)
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     length,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  input  logic [DATA_WIDTH-1:0]   ram_dout,
  ram_stream_reader_if.master     m
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [ADDR_WIDTH:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]     recv_cnt_q, recv_cnt_d;
  logic                    inflight_q;
  logic                    done_q, done_d;

  // Two-entry output buffer
  logic [DATA_WIDTH-1:0]   buf_q [2];
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              count_q, count_d;

  logic                    push, pop, issue;
  logic [2:0]              occ;

  // Data returned by the RAM lands in the buffer the cycle after the issue.
  assign push = inflight_q;
  assign pop  = m.m_valid & m.m_ready;

  // Occupancy counts the word leaving this cycle as already gone, so a new
  // read can be issued every cycle while the consumer keeps up. Issued reads
  // plus buffered words never exceed two, so the buffer cannot overflow.
  assign occ   = {2'b00, inflight_q} + {1'b0, count_q} - {2'b00, pop};
  assign issue = (state_q == RUN) && (issue_cnt_q != '0) && (occ < 3'd2);

  // The address is presented combinationally in the issue cycle; otherwise
  // the last issued address is held.
  assign ram_raddr = issue ? addr_q : raddr_q;

  assign m.m_valid = (count_q != 2'd0);
  assign m.m_data  = m.m_valid ? buf_q[rd_ptr_q] : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    raddr_d     = raddr_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    done_d      = 1'b0;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};

    if (pop) begin
      recv_cnt_d = recv_cnt_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = RUN;
            addr_d      = start_addr;
            issue_cnt_d = length;
            recv_cnt_d  = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue) begin
          raddr_d     = addr_q;
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - 1'b1;
          if (issue_cnt_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (recv_cnt_q == {{ADDR_WIDTH{1'b0}}, 1'b1})) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      raddr_q     <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      raddr_q     <= raddr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      inflight_q  <= issue;
      done_q      <= done_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Buffer storage needs no reset: an empty buffer masks its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          sync_reset, start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          busy, done;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] mem [DEPTH];

  ram_stream_reader_if #(.DATA_WIDTH(DW)) sif ();

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ram_raddr  (ram_raddr),
    .ram_dout   (ram_dout),
    .m          (sif)
  );

  always #5 clk = ~clk;

  // RAM read port: registered address, data one cycle later.
  always @(posedge clk) ram_dout <= mem[ram_raddr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected word queue, busy and done derived from the
  // command rules; delivered words are logged for literal checks.
  logic [31:0] expq[$];
  logic [31:0] got[$];
  bit          chk_en   = 1'b0;
  bit          busy_exp = 1'b0;
  bit          done_exp = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit nb;
      bit nd;
      chk("busy", busy, busy_exp);
      chk("done", done, done_exp);
      if (expq.size() == 0) chk("m_valid_when_empty", sif.m_valid, 0);
      else if (sif.m_valid) chk("m_data", sif.m_data, expq[0]);
      nb = busy_exp;
      nd = 1'b0;
      if (sif.m_valid && sif.m_ready && expq.size() != 0) begin
        got.push_back(sif.m_data);
        void'(expq.pop_front());
        if (expq.size() == 0) begin
          nb = 1'b0;
          nd = 1'b1;
        end
      end
      if (start && !busy_exp && !sync_reset) begin
        if (length == 0) nd = 1'b1;
        else begin
          for (int i = 0; i < int'(length); i++)
            expq.push_back(mem[(int'(start_addr) + i) % DEPTH]);
          nb = 1'b1;
        end
      end
      if (sync_reset) begin
        expq.delete();
        nb = 1'b0;
        nd = 1'b0;
      end
      busy_exp = nb;
      done_exp = nd;
    end
  end

  task automatic do_start(input int a, input int l);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = AW'(a);
    length = (AW+1)'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit rnd);
    bit seen = 1'b0;
    int stall = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (!rnd) sif.m_ready = 1'b1;
      else if (stall > 0) begin
        sif.m_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 9) == 0) begin
        sif.m_ready = 1'b0;
        stall = 4;
      end else sif.m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!seen) chk("timeout_done", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + i;
    sync_reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    length = '0;
    sif.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_m_valid", sif.m_valid, 0);
    chk("rst_m_data", sif.m_data, 0);
    chk("rst_ram_raddr", ram_raddr, 0);
    @(posedge clk); #1;
    sync_reset = 1'b0;
    chk_en = 1'b1;

    // Basic block: addr 3, length 4, consumer always ready.
    sif.m_ready = 1'b1;
    got.delete();
    do_start(3, 4);
    @(negedge clk);
    chk("t1_busy_c1", busy, 1);
    chk("t1_valid_c1", sif.m_valid, 0);
    @(negedge clk);
    chk("t1_valid_c2", sif.m_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid_word", sif.m_valid, 1);
      chk("t1_data_word", sif.m_data, 32'h103 + k);
    end
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    // Address wrap: 30, 31, 0, 1.
    got.delete();
    do_start(30, 4);
    run_until_done(50, 1'b0);
    chk("t2_count", got.size(), 4);
    chk("t2_w0", got[0], 32'h11E);
    chk("t2_w1", got[1], 32'h11F);
    chk("t2_w2", got[2], 32'h100);
    chk("t2_w3", got[3], 32'h101);

    // Zero length: done next cycle, never busy.
    do_start(5, 0);
    @(negedge clk);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_valid", sif.m_valid, 0);
    @(negedge clk);
    chk("t3_done_pulse", done, 0);

    // Whole RAM with random back-pressure and 5-cycle stalls.
    got.delete();
    do_start(7, 32);
    run_until_done(800, 1'b1);
    chk("t4_count", got.size(), 32);
    chk("t4_first", got[0], 32'h107);
    chk("t4_top", got[24], 32'h11F);
    chk("t4_wrap", got[25], 32'h100);
    chk("t4_last", got[31], 32'h106);
    sif.m_ready = 1'b1;

    // Reset in the middle of a length-10 transfer, then a fresh transfer.
    got.delete();
    do_start(0, 10);
    repeat (4) @(posedge clk);
    #1 sync_reset = 1'b1;
    @(posedge clk); #1;
    sync_reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_valid", sif.m_valid, 0);
    chk("t5_raddr", ram_raddr, 0);
    chk("t5_done", done, 0);
    chk("t5_count_before", got.size(), 3);
    do_start(20, 3);
    run_until_done(50, 1'b0);
    chk("t5_count_after", got.size(), 6);
    chk("t5_w3", got[3], 32'h114);
    chk("t5_w5", got[5], 32'h116);

    // Start while busy is ignored.
    got.delete();
    do_start(10, 5);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = AW'(0);
    length = (AW+1)'(3);
    @(posedge clk); #1;
    start = 1'b0;
    run_until_done(50, 1'b0);
    chk("t6_count", got.size(), 5);
    chk("t6_first", got[0], 32'h10A);
    chk("t6_last", got[4], 32'h10E);
    repeat (3) @(negedge clk);
    chk("t6_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
